// File: rtl/alu_acc_pkg.sv
// rtl/alu_acc_pkg.sv - opcode constants, flag bit indices and opcode decode for the accumulator ALU
package alu_acc_pkg;

   localparam logic [7:0] OPC_LOAD_I  = 8'h01;
   localparam logic [7:0] OPC_LOAD_X  = 8'h02;
   localparam logic [1:0] CLS_ARITH   = 2'b01;
   localparam logic [1:0] CLS_LOGIC   = 2'b10;
   localparam logic [7:0] OPC_SHL     = 8'hC0;
   localparam logic [7:0] OPC_SHR     = 8'hC1;
   localparam logic [7:0] OPC_ROL     = 8'hC2;
   localparam logic [7:0] OPC_ROR     = 8'hC3;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_OV    = 3;

   typedef enum logic [3:0] {
      OP_NONE,
      OP_ADD, OP_ADC, OP_SUB, OP_SBB,
      OP_AND, OP_OR,  OP_XOR, OP_NOT,
      OP_SHL, OP_SHR, OP_ROL, OP_ROR,
      OP_LDI, OP_LDX
   } alu_op_e;

   // Anything not recognised here (jumps, stores, NOP, holes in the ALU classes) decodes to OP_NONE.
   function automatic alu_op_e decode_op(input logic [7:0] ir);
      alu_op_e op;
      op = OP_NONE;
      if (ir == OPC_LOAD_I) begin
         op = OP_LDI;
      end else if (ir == OPC_LOAD_X) begin
         op = OP_LDX;
      end else if (ir[7:6] == CLS_ARITH && ir[5:3] == 3'b000) begin
         case (ir[1:0])
            2'b00:   op = OP_ADD;
            2'b01:   op = OP_ADC;
            2'b10:   op = OP_SUB;
            default: op = OP_SBB;
         endcase
      end else if (ir[7:6] == CLS_LOGIC && ir[5:3] == 3'b000) begin
         case (ir[1:0])
            2'b00:   op = OP_AND;
            2'b01:   op = OP_OR;
            2'b10:   op = OP_XOR;
            default: op = OP_NOT;
         endcase
      end else begin
         case (ir)
            OPC_SHL: op = OP_SHL;
            OPC_SHR: op = OP_SHR;
            OPC_ROL: op = OP_ROL;
            OPC_ROR: op = OP_ROR;
            default: op = OP_NONE;
         endcase
      end
      return op;
   endfunction

   // Arithmetic and shifts own CARRY/OV; logic ops and loads leave them alone.
   function automatic logic op_writes_cv(input alu_op_e op);
      return (op inside {OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_SHL, OP_SHR, OP_ROL, OP_ROR});
   endfunction

endpackage

// File: rtl/alu_acc_core.sv
// rtl/alu_acc_core.sv - combinational ALU datapath: result, carry/borrow and overflow
module alu_core
   import alu_acc_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  alu_op_e               op,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic                  Cin,
   output logic [DATA_WIDTH-1:0] R,
   output logic                  C,
   output logic                  V
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH:0] sum;
   logic [DATA_WIDTH:0] diff;
   logic                cin_add;
   logic                bin_sub;

   assign cin_add = (op == OP_ADC) ? Cin : 1'b0;
   assign bin_sub = (op == OP_SBB) ? Cin : 1'b0;
   // Extra top bit holds carry-out for add and the unsigned borrow for subtract.
   assign sum  = {1'b0, A} + {1'b0, B} + {{DATA_WIDTH{1'b0}}, cin_add};
   assign diff = {1'b0, A} - {1'b0, B} - {{DATA_WIDTH{1'b0}}, bin_sub};

   // Select result and carry/overflow by operation; C passes Cin through where it is not produced.
   always_comb begin
      R = A;
      C = Cin;
      V = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            R = sum[MSB:0];
            C = sum[DATA_WIDTH];
            V = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_SUB, OP_SBB: begin
            R = diff[MSB:0];
            C = diff[DATA_WIDTH];
            V = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
         end
         OP_AND: R = A & B;
         OP_OR:  R = A | B;
         OP_XOR: R = A ^ B;
         OP_NOT: R = ~A;
         OP_SHL: begin
            R = {A[MSB-1:0], 1'b0};
            C = A[MSB];
         end
         OP_SHR: begin
            R = {1'b0, A[MSB:1]};
            C = A[0];
         end
         OP_ROL: begin
            R = {A[MSB-1:0], Cin};
            C = A[MSB];
         end
         OP_ROR: begin
            R = {Cin, A[MSB:1]};
            C = A[0];
         end
         OP_LDI, OP_LDX: R = B;
         default: begin
            R = A;
            C = Cin;
         end
      endcase
   end

endmodule

// File: rtl/alu_acc.sv
// rtl/alu_acc.sv - accumulator and flag registers with execute gating around alu_core
module alu_acc
   import alu_acc_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  Exec,
   input  logic [DATA_WIDTH-1:0] IR,
   input  logic [DATA_WIDTH-1:0] IBR,
   input  logic [DATA_WIDTH-1:0] MBR,
   output logic [DATA_WIDTH-1:0] AR,
   output logic [3:0]            Flags
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] ar_q, ar_d;
   logic [3:0]            flags_q, flags_d;
   alu_op_e               op;
   logic [DATA_WIDTH-1:0] operand_b;
   logic [DATA_WIDTH-1:0] core_r;
   logic                  core_c;
   logic                  core_v;

   assign op = decode_op(IR[7:0]);

   // Loads name their source directly; ALU classes pick MBR/IBR with IR[2].
   always_comb begin
      operand_b = MBR;
      if (op == OP_LDI) begin
         operand_b = IBR;
      end else if (op == OP_LDX) begin
         operand_b = MBR;
      end else if (IR[2]) begin
         operand_b = IBR;
      end
   end

   alu_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu_core (
      .op  (op),
      .A   (ar_q),
      .B   (operand_b),
      .Cin (flags_q[FLAG_CARRY]),
      .R   (core_r),
      .C   (core_c),
      .V   (core_v)
   );

   // Next accumulator/flags: only a recognised op under Exec changes anything.
   always_comb begin
      ar_d    = ar_q;
      flags_d = flags_q;
      if (Exec && op != OP_NONE) begin
         ar_d              = core_r;
         flags_d[FLAG_ZERO] = (core_r == '0);
         flags_d[FLAG_NEG]  = core_r[MSB];
         if (op_writes_cv(op)) begin
            flags_d[FLAG_CARRY] = core_c;
            flags_d[FLAG_OV]    = core_v;
         end
      end
   end

   // State registers; reset wins over Exec and leaves only ZERO set.
   always_ff @(posedge clk) begin
      if (arst) begin
         ar_q    <= '0;
         flags_q <= 4'b0001;
      end else begin
         ar_q    <= ar_d;
         flags_q <= flags_d;
      end
   end

   assign AR    = ar_q;
   assign Flags = flags_q;

endmodule

// File: tb/tb_alu_acc.sv
// tb/tb_alu_acc.sv - directed self-checking bench for alu_acc
module tb_alu_acc;

   logic       clk;
   logic       arst;
   logic       Exec;
   logic [7:0] IR;
   logic [7:0] IBR;
   logic [7:0] MBR;
   logic [7:0] AR;
   logic [3:0] Flags;

   int checks = 0;
   int errors = 0;

   alu_acc #(.DATA_WIDTH(8)) dut (
      .clk   (clk),
      .arst  (arst),
      .Exec  (Exec),
      .IR    (IR),
      .IBR   (IBR),
      .MBR   (MBR),
      .AR    (AR),
      .Flags (Flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: drive inputs away from the edge, clock, then check on the falling edge.
   task automatic step(input string tag, input logic rst, input logic ex,
                       input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr,
                       input logic [7:0] exp_ar, input logic [3:0] exp_fl);
      arst = rst;
      Exec = ex;
      IR   = ir;
      IBR  = ibr;
      MBR  = mbr;
      @(posedge clk);
      @(negedge clk);
      checks++;
      assert (AR === exp_ar) else begin
         errors++;
         $error("FAIL %s AR got %h expected %h", tag, AR, exp_ar);
      end
      checks++;
      assert (Flags === exp_fl) else begin
         errors++;
         $error("FAIL %s Flags got %b expected %b", tag, Flags, exp_fl);
      end
   endtask

   initial begin
      arst = 1'b1;
      Exec = 1'b0;
      IR   = 8'h00;
      IBR  = 8'h00;
      MBR  = 8'h00;
      @(negedge clk);

      // Reset, then idle
      step("reset",   1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0001);
      for (int i = 0; i < 5; i++)
         step("idle",  1'b0, 1'b0, 8'h44, 8'h55, 8'h66, 8'h00, 4'b0001);

      // 0x7F + 1 signed overflow
      step("ldi_7f",  1'b0, 1'b1, 8'h01, 8'h7F, 8'h00, 8'h7F, 4'b0000);
      step("add_ov",  1'b0, 1'b1, 8'h44, 8'h01, 8'h00, 8'h80, 4'b1100);

      // Carry out then ADC consumes it
      step("ldi_ff",  1'b0, 1'b1, 8'h01, 8'hFF, 8'h00, 8'hFF, 4'b1100);
      step("add_c",   1'b0, 1'b1, 8'h44, 8'h01, 8'h00, 8'h00, 4'b0011);
      step("adc",     1'b0, 1'b1, 8'h45, 8'h00, 8'h00, 8'h01, 4'b0000);

      // Memory operands, borrow, and Exec=0 hold
      step("ldx_10",  1'b0, 1'b1, 8'h02, 8'hAA, 8'h10, 8'h10, 4'b0000);
      step("sub_mem", 1'b0, 1'b1, 8'h42, 8'hAA, 8'h20, 8'hF0, 4'b0110);
      step("hold",    1'b0, 1'b0, 8'h44, 8'h05, 8'h05, 8'hF0, 4'b0110);

      // Shifts/rotates through carry, XOR to zero leaves carry
      step("ldi_81",  1'b0, 1'b1, 8'h01, 8'h81, 8'h00, 8'h81, 4'b0110);
      step("shl",     1'b0, 1'b1, 8'hC0, 8'h00, 8'h00, 8'h02, 4'b0010);
      step("ror",     1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h81, 4'b0100);
      step("xor_imm", 1'b0, 1'b1, 8'h86, 8'h81, 8'h00, 8'h00, 4'b0001);

      // Borrow chain, undefined class-01 opcode, NOT, subtract overflow, SHR/ROL
      step("ldi_00",  1'b0, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 4'b0001);
      step("sub_imm", 1'b0, 1'b1, 8'h46, 8'h01, 8'h00, 8'hFF, 4'b0110);
      step("sbb_imm", 1'b0, 1'b1, 8'h47, 8'h00, 8'h00, 8'hFE, 4'b0100);
      step("undef48", 1'b0, 1'b1, 8'h48, 8'h00, 8'h00, 8'hFE, 4'b0100);
      step("not",     1'b0, 1'b1, 8'h83, 8'h00, 8'h00, 8'h01, 4'b0000);
      step("ldi_80",  1'b0, 1'b1, 8'h01, 8'h80, 8'h00, 8'h80, 4'b0100);
      step("sub_ov",  1'b0, 1'b1, 8'h46, 8'h01, 8'h00, 8'h7F, 4'b1000);
      step("shr",     1'b0, 1'b1, 8'hC1, 8'h00, 8'h00, 8'h3F, 4'b0010);
      step("rol",     1'b0, 1'b1, 8'hC2, 8'h00, 8'h00, 8'h7F, 4'b0000);
      step("and_mem", 1'b0, 1'b1, 8'h80, 8'h00, 8'h0F, 8'h0F, 4'b0000);
      step("or_imm",  1'b0, 1'b1, 8'h85, 8'hF0, 8'h00, 8'hFF, 4'b0100);

      // Reset in the middle of a back-to-back ADD stream
      step("ldi_05",  1'b0, 1'b1, 8'h01, 8'h05, 8'h00, 8'h05, 4'b0000);
      step("add_s1",  1'b0, 1'b1, 8'h44, 8'hFF, 8'h00, 8'h04, 4'b0010);
      step("rst_mid", 1'b1, 1'b1, 8'h44, 8'h01, 8'h00, 8'h00, 4'b0001);
      step("ldi_pr",  1'b0, 1'b1, 8'h01, 8'h05, 8'h00, 8'h05, 4'b0000);
      step("adc_pr",  1'b0, 1'b1, 8'h45, 8'h01, 8'h00, 8'h06, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
